// File: rtl/tick_bcd_stopwatch.sv
// Four-digit BCD stopwatch with a multiplexed active-low seven-segment display.
// Optional lap/freeze display feature enabled by defining STOPWATCH_LAP_EN.
module tick_bcd_stopwatch #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] count,
  output logic        running,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t            state;
  logic [15:0]       count_inc;
  logic [15:0]       display;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [3:0]        digit;
  logic [3:0]        an_next;
  logic              carry;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Ripple BCD increment: each digit rolls 9 -> 0 and passes the carry upward.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[i*4 +: 4] == 4'd9) begin
          count_inc[i*4 +: 4] = 4'd0;
        end else begin
          count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Clear outranks start_stop, which outranks tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 16'h0000;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        count   <= 16'h0000;
        running <= 1'b0;
      end else if (start_stop) begin
        if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (tick && state == RUN) begin
        count <= count_inc;
        wrap  <= (count == 16'h9999);
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        frozen;
  logic [15:0] lap_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen  <= 1'b0;
      lap_reg <= 16'h0000;
    end else if (clear) begin
      frozen <= 1'b0;
    end else if (lap && state == RUN) begin
      if (frozen) begin
        frozen <= 1'b0;
      end else begin
        frozen  <= 1'b1;
        lap_reg <= count;
      end
    end
  end

  assign display = frozen ? lap_reg : count;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign display    = count;
`endif

  always_comb begin
    case (digit_idx)
      2'd0:    begin digit = display[3:0];   an_next = 4'b1110; end
      2'd1:    begin digit = display[7:4];   an_next = 4'b1101; end
      2'd2:    begin digit = display[11:8];  an_next = 4'b1011; end
      default: begin digit = display[15:12]; an_next = 4'b0111; end
    endcase
  end

  // an and seg are registered from the same index so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      an        <= 4'b1110;
      seg       <= 7'b1000000;
    end else begin
      an  <= an_next;
      seg <= seg_of(digit);
      if (scan_cnt == SCAN_MAX) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

endmodule
